// File: rtl/regfile_sb_pkg.sv
// Shared defaults and constants for the regfile_sb GPR file and its scoreboard.
package regfile_sb_pkg;

    localparam int   REG_BUS_W  = 32;
    localparam int   REG_ADDR_W = 5;
    localparam logic RST_ASSERT = 1'b0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// regfile_scoreboard: pending-write bit per register.
// Priority is flush > set > writeback clear; register 0 is never pending.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter  int ADDR_W = REG_ADDR_W,
    parameter  int NUM_WR = 2,
    localparam int DEPTH  = 1 << ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    input  logic                     sb_flush,
    output logic [DEPTH-1:0]         pending
);

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pending_nxt;
    logic [DEPTH-1:0] w_clr;
    logic [DEPTH-1:0] w_set;

    // Next pending vector; a set beats a same-cycle writeback clear (new producer wins)
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            w_clr[waddr[i*ADDR_W +: ADDR_W]] = w_clr[waddr[i*ADDR_W +: ADDR_W]] | we[i];
        end
        w_set              = '0;
        w_set[sb_set_addr] = sb_set;
        if (sb_flush) begin
            w_pending_nxt = '0;
        end else begin
            w_pending_nxt = (r_pending & ~w_clr) | w_set;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Pending-bit state register
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ASSERT) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign pending = r_pending;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port GPR file with pending-write scoreboard and per-read valid flag.
// Define REGFILE_SB_BYPASS_EN to enable same-cycle write-to-read forwarding.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int DATA_W = REG_BUS_W,
    parameter  int ADDR_W = REG_ADDR_W,
    parameter  int NUM_RD = 2,
    parameter  int NUM_WR = 2,
    localparam int DEPTH  = 1 << ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rvalid,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    input  logic                     sb_flush,
    output logic [DEPTH-1:0]         pending
);

    logic [DATA_W-1:0] r_regs    [DEPTH];
    logic [DEPTH-1:0]  w_wr_en;
    logic [DATA_W-1:0] w_wr_data [DEPTH];
    logic [ADDR_W-1:0] w_ra      [NUM_RD];
    logic [DEPTH-1:0]  w_pending;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .waddr       (waddr),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .sb_flush    (sb_flush),
        .pending     (w_pending)
    );

    assign pending = w_pending;

    // Per-register write select; ascending scan lets the highest-index port win
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_wr_en[k]   = 1'b0;
            w_wr_data[k] = '0;
            for (int i = 0; i < NUM_WR; i++) begin
                if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == ADDR_W'(k)) && (k != 0)) begin
                    w_wr_en[k]   = 1'b1;
                    w_wr_data[k] = wdata[i*DATA_W +: DATA_W];
                end else begin
                    w_wr_en[k]   = w_wr_en[k];
                end
            end
        end
    end

    // Register array
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ASSERT) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_wr_en[k]) begin
                    r_regs[k] <= w_wr_data[k];
                end
            end
        end
    end

    // Read muxing; disabled ports, r0 and reset force zero data marked valid
    always_comb begin
        rdata  = '0;
        rvalid = '1;
        for (int j = 0; j < NUM_RD; j++) begin
            w_ra[j]                   = raddr[j*ADDR_W +: ADDR_W];
            rdata[j*DATA_W +: DATA_W] = r_regs[w_ra[j]];
            rvalid[j]                 = ~w_pending[w_ra[j]];
`ifdef REGFILE_SB_BYPASS_EN
            for (int i = 0; i < NUM_WR; i++) begin
                if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == w_ra[j])) begin
                    rdata[j*DATA_W +: DATA_W] = wdata[i*DATA_W +: DATA_W];
                    rvalid[j]                 = 1'b1;
                end else begin
                    rvalid[j]                 = rvalid[j];
                end
            end
`endif
            if (!re[j] || (w_ra[j] == {ADDR_W{1'b0}}) || (rst == RST_ASSERT)) begin
                rdata[j*DATA_W +: DATA_W] = '0;
                rvalid[j]                 = 1'b1;
            end else begin
                rvalid[j]                 = rvalid[j];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then random traffic against a reference model.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rvalid;
    logic        sb_set;
    logic [4:0]  sb_set_addr;
    logic        sb_flush;
    logic [31:0] pending;

    int total = 0;
    int bad   = 0;

    logic [31:0] mregs [32];
    logic [31:0] mpend;

    regfile_sb dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .re          (re),
        .raddr       (raddr),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .sb_flush    (sb_flush),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we = 2'b00; waddr = '0; wdata = '0;
        re = 2'b00; raddr = '0;
        sb_set = 1'b0; sb_set_addr = 5'd0; sb_flush = 1'b0;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 32; k++) mregs[k] = 32'h0;
        mpend = 32'h0;
    endtask

    // Expected read result from the architectural rules
    task automatic expect_read(input int j, output logic [31:0] d, output logic v);
        logic [4:0] a;
        a = raddr[j*5 +: 5];
        d = mregs[a];
        v = !mpend[a];
        if (BYP) begin
            for (int i = 1; i >= 0; i--) begin
                if (we[i] && waddr[i*5 +: 5] == a) begin
                    d = wdata[i*32 +: 32];
                    v = 1'b1;
                    break;
                end
            end
        end
        if (!re[j] || a == 5'd0) begin
            d = 32'h0;
            v = 1'b1;
        end
    endtask

    task automatic model_update();
        logic [31:0] np;
        logic [4:0]  a;
        np = mpend;
        for (int i = 0; i < 2; i++) begin
            a = waddr[i*5 +: 5];
            if (we[i] && a != 5'd0) mregs[a] = wdata[i*32 +: 32];
        end
        if (sb_flush) begin
            np = 32'h0;
        end else begin
            for (int i = 0; i < 2; i++) if (we[i]) np[waddr[i*5 +: 5]] = 1'b0;
            if (sb_set && sb_set_addr != 5'd0) np[sb_set_addr] = 1'b1;
        end
        np[0] = 1'b0;
        mpend = np;
    endtask

    // Check all outputs against the model, then advance one clock
    task automatic step(input string tag);
        logic [31:0] d;
        logic        v;
        #1;
        for (int j = 0; j < 2; j++) begin
            expect_read(j, d, v);
            chk($sformatf("%s.rdata%0d", tag, j), rdata[j*32 +: 32], d);
            chk($sformatf("%s.rvalid%0d", tag, j), rvalid[j], v);
        end
        chk($sformatf("%s.pending", tag), pending, mpend);
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        model_clear();
        re = 2'b11; raddr = {5'd3, 5'd1};
        #3;
        chk("rst0.rdata", rdata, 64'h0);
        chk("rst0.rvalid", rvalid, 2'b11);
        chk("rst0.pending", pending, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // forwarding on a same-cycle write
        idle(); we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'h12345678;
        step("pre5");
        idle(); we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF;
        re = 2'b10; raddr[9:5] = 5'd5;
        #1;
        chk("fwd.rdata1", rdata[63:32], BYP ? 64'hDEADBEEF : 64'h12345678);
        chk("fwd.rvalid1", rvalid[1], 1'b1);
        step("fwd");
        idle(); re = 2'b11; raddr = {5'd5, 5'd5};
        #1;
        chk("r5next.rdata0", rdata[31:0], 32'hDEADBEEF);
        step("r5next");

        // write-port conflict and r0
        idle(); we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11};
        step("conf");
        idle(); we = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'hFFFFFFFF;
        re = 2'b11; raddr = {5'd0, 5'd7};
        #1;
        chk("conf.r7", rdata[31:0], 32'h22);
        chk("r0.fwd", rdata[63:32], 32'h0);
        step("r0w");
        idle(); re = 2'b10; raddr[9:5] = 5'd0;
        #1;
        chk("r0.after", rdata[63:32], 32'h0);
        step("r0r");

        // load-use hazard on r9
        idle(); sb_set = 1'b1; sb_set_addr = 5'd9;
        step("set9");
        idle(); re = 2'b01; raddr[4:0] = 5'd9;
        #1;
        chk("r9.stale", rvalid[0], 1'b0);
        chk("r9.pend", pending[9], 1'b1);
        step("r9stale");
        idle(); re = 2'b01; raddr[4:0] = 5'd9; we = 2'b10; waddr[9:5] = 5'd9; wdata[63:32] = 32'h5;
        #1;
        chk("r9.wbcyc", rvalid[0], BYP);
        step("r9wb");
        idle(); re = 2'b01; raddr[4:0] = 5'd9;
        #1;
        chk("r9.valid", rvalid[0], 1'b1);
        chk("r9.data", rdata[31:0], 32'h5);
        step("r9ok");

        // set wins over same-cycle writeback clear
        idle(); sb_set = 1'b1; sb_set_addr = 5'd3;
        step("set3");
        idle(); we = 2'b01; waddr[4:0] = 5'd3; wdata[31:0] = 32'hAA; sb_set = 1'b1; sb_set_addr = 5'd3;
        step("set3wb");
        #1;
        chk("r3.pend", pending[3], 1'b1);

        // flush beats set
        idle(); sb_set = 1'b1; sb_set_addr = 5'd4;
        step("set4");
        idle(); sb_set = 1'b1; sb_set_addr = 5'd6;
        step("set6");
        #1;
        chk("p46", {pending[6], pending[4]}, 2'b11);
        idle(); sb_flush = 1'b1; sb_set = 1'b1; sb_set_addr = 5'd8;
        step("flush");
        #1;
        chk("flush.pending", pending, 32'h0);
        idle(); sb_set = 1'b1; sb_set_addr = 5'd0;
        step("set0");
        #1;
        chk("set0.pending", pending, 32'h0);

        // asynchronous reset mid-run
        idle(); sb_set = 1'b1; sb_set_addr = 5'd12;
        step("set12");
        idle(); we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hCAFE;
        re = 2'b11; raddr = {5'd12, 5'd5};
        #2;
        rst = 1'b0;
        #1;
        chk("mrst.rdata", rdata, 64'h0);
        chk("mrst.rvalid", rvalid, 2'b11);
        chk("mrst.pending", pending, 32'h0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        idle();
        rst = 1'b1;
        re = 2'b11; raddr = {5'd7, 5'd5};
        #1;
        chk("post.rdata", rdata, 64'h0);
        step("post");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            we          = 2'($urandom_range(0, 3));
            waddr       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wdata       = {$urandom, $urandom};
            re          = 2'($urandom_range(0, 3));
            raddr       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            sb_set      = 1'($urandom_range(0, 1));
            sb_set_addr = 5'($urandom_range(0, 7));
            sb_flush    = ($urandom_range(0, 15) == 0);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
